// File: rtl/pixel_frame_collector.sv
// Receive end of the pixel stream: captures complete IMG_W x IMG_H frames into a
// two-bank ping-pong buffer for random-access reads by the downstream conv layer.
module pixel_frame_collector #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int NPIX   = IMG_W * IMG_H,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        pixel_in,
    input  logic              valid_in,
    output logic [4:0]        wr_row,
    output logic [4:0]        wr_col,
    output logic              frame_done,
    output logic              frame_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              frame_release,
    output logic [7:0]        drop_cnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [4:0]        LAST_COL  = 5'(IMG_W - 1);

    typedef enum logic {ST_CAPTURE, ST_DROP} state_t;
    state_t state, state_nx;

    logic [7:0]        mem [2][NPIX];
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_bank, rd_bank;
    logic [1:0]        bank_full, bank_full_nx;
    logic              frame_start, frame_end, dropping, capture_done, release_ok;

    assign frame_ready = bank_full[rd_bank];

    // The drop decision is taken on the first beat from the registered bank_full,
    // so a release in that same cycle cannot rescue the frame.
    always_comb begin
        frame_start  = valid_in && (wr_addr == '0);
        frame_end    = valid_in && (wr_addr == LAST_ADDR);
        dropping     = (wr_addr == '0) ? bank_full[wr_bank] : (state == ST_DROP);
        capture_done = frame_end && !dropping;
        release_ok   = frame_release && bank_full[rd_bank];

        state_nx = state;
        if (frame_end)
            state_nx = ST_CAPTURE;
        else if (frame_start)
            state_nx = bank_full[wr_bank] ? ST_DROP : ST_CAPTURE;

        bank_full_nx = bank_full;
        if (capture_done) bank_full_nx[wr_bank] = 1'b1;
        if (release_ok)   bank_full_nx[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_CAPTURE;
            wr_addr    <= '0;
            wr_row     <= '0;
            wr_col     <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            bank_full  <= '0;
            frame_done <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            state      <= state_nx;
            frame_done <= capture_done;
            bank_full  <= bank_full_nx;
            if (valid_in) begin
                if (frame_end) begin
                    wr_addr <= '0;
                    wr_row  <= '0;
                    wr_col  <= '0;
                    if (dropping && drop_cnt != '1)
                        drop_cnt <= drop_cnt + 1'b1;
                end else begin
                    wr_addr <= wr_addr + 1'b1;
                    if (wr_col == LAST_COL) begin
                        wr_col <= '0;
                        wr_row <= wr_row + 1'b1;
                    end else begin
                        wr_col <= wr_col + 1'b1;
                    end
                end
            end
            if (capture_done) wr_bank <= ~wr_bank;
            if (release_ok)   rd_bank <= ~rd_bank;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && valid_in && !dropping)
            mem[wr_bank][wr_addr] <= pixel_in;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                if (frame_ready && rd_addr <= LAST_ADDR)
                    rd_data <= mem[rd_bank][rd_addr];
                else
                    rd_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_frame_collector.sv
// Bench for pixel_frame_collector: random frames checked against a queue-of-frames
// model of the ping-pong buffer (capture order, drop when two frames are held).
module tb_pixel_frame_collector;

    localparam int W    = 28;
    localparam int NPIX = 784;

    typedef logic [7:0] frame_t [NPIX];

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] pixel_in = '0;
    logic       valid_in = 1'b0;
    logic [4:0] wr_row, wr_col;
    logic       frame_done, frame_ready;
    logic       rd_en = 1'b0;
    logic [9:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       frame_release = 1'b0;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    // Model: captured frames in capture order; front is what the reader sees.
    frame_t fq[$];
    int     exp_drop = 0;

    pixel_frame_collector #(.IMG_W(28), .IMG_H(28), .ADDR_W(10)) dut (
        .clk(clk), .rstn(rstn), .pixel_in(pixel_in), .valid_in(valid_in),
        .wr_row(wr_row), .wr_col(wr_col), .frame_done(frame_done),
        .frame_ready(frame_ready), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .frame_release(frame_release),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_read(input int addr);
        if (fq.size() == 0 || addr >= NPIX) return 8'h00;
        return fq[0][addr];
    endfunction

    task automatic chk_rowcol(input string tag, input int b);
        checks++;
        if (wr_row !== 5'(b / W) || wr_col !== 5'(b % W)) begin
            errors++;
            $display("FAIL %s rowcol beat %0d: got row=%0d col=%0d, want row=%0d col=%0d",
                     tag, b, wr_row, wr_col, b / W, b % W);
        end
    endtask

    task automatic chk_status(input string tag);
        checks++;
        if (frame_ready !== (fq.size() > 0)) begin
            errors++;
            $display("FAIL %s frame_ready: got %b want %b", tag, frame_ready, fq.size() > 0);
        end
        checks++;
        if (drop_cnt !== 8'(exp_drop)) begin
            errors++;
            $display("FAIL %s drop_cnt: got %0d want %0d", tag, drop_cnt, exp_drop);
        end
    endtask

    // mode 0: pixel = addr[7:0]; otherwise random pixels.
    task automatic send_frame(input string tag, input int mode, input bit gaps,
                              input bit rel_first, input int nbeats);
        frame_t f;
        bit drop;
        drop = (fq.size() == 2);
        for (int b = 0; b < NPIX; b++) f[b] = (mode == 0) ? 8'(b) : 8'($urandom);
        for (int b = 0; b < nbeats; b++) begin
            while (gaps && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk_rowcol(tag, b);
                valid_in = 1'b0;
                frame_release = 1'b0;
            end
            @(negedge clk);
            chk_rowcol(tag, b);
            valid_in = 1'b1;
            pixel_in = f[b];
            frame_release = rel_first && (b == 0);
            if (rel_first && b == 0 && fq.size() > 0) void'(fq.pop_front());
        end
        @(negedge clk);
        valid_in = 1'b0;
        frame_release = 1'b0;
        if (nbeats == NPIX) begin
            checks++;
            if (frame_done !== !drop) begin
                errors++;
                $display("FAIL %s frame_done pulse: got %b want %b", tag, frame_done, !drop);
            end
            chk_rowcol(tag, 0);
            if (drop) begin
                if (exp_drop < 255) exp_drop++;
            end else begin
                fq.push_back(f);
            end
            @(negedge clk);
            checks++;
            if (frame_done !== 1'b0) begin
                errors++;
                $display("FAIL %s frame_done width: got %b want 0", tag, frame_done);
            end
            chk_status(tag);
        end
    endtask

    task automatic read_check(input string tag, input int addr, input logic [7:0] exp);
        @(negedge clk);
        rd_en = 1'b1;
        rd_addr = 10'(addr);
        @(negedge clk);
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++;
            $display("FAIL %s read addr %0d: got valid=%b data=%h want valid=1 data=%h",
                     tag, addr, rd_valid, rd_data, exp);
        end
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== exp) begin
            errors++;
            $display("FAIL %s read hold addr %0d: got valid=%b data=%h want valid=0 data=%h",
                     tag, addr, rd_valid, rd_data, exp);
        end
    endtask

    task automatic read_random(input string tag, input int n);
        int a;
        for (int i = 0; i < n; i++) begin
            a = $urandom_range(0, NPIX - 1);
            read_check(tag, a, model_read(a));
        end
    endtask

    task automatic release_bank(input string tag);
        @(negedge clk);
        frame_release = 1'b1;
        if (fq.size() > 0) void'(fq.pop_front());
        @(negedge clk);
        frame_release = 1'b0;
        chk_status(tag);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rstn = 1'b0;
        valid_in = 1'b0;
        rd_en = 1'b0;
        frame_release = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        fq.delete();
        exp_drop = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: got rd_valid=%b rd_data=%h frame_done=%b want 0/00/0",
                     rd_valid, rd_data, frame_done);
        end
        chk_rowcol("reset", 0);
        chk_status("reset");
    endtask

    task automatic test_single_frame();
        send_frame("single", 0, 1'b0, 1'b0, NPIX);
        read_check("single", 0,   8'h00);
        read_check("single", 27,  8'h1B);
        read_check("single", 28,  8'h1C);
        read_check("single", 783, 8'h0F);
        release_bank("single");
    endtask

    task automatic test_rowcol_gaps();
        send_frame("gaps", 1, 1'b1, 1'b0, NPIX);
        read_random("gaps", 4);
        release_bank("gaps");
    endtask

    task automatic test_back_to_back();
        send_frame("b2b_A", 1, 1'b0, 1'b0, NPIX);
        send_frame("b2b_B", 1, 1'b0, 1'b0, NPIX);
        send_frame("b2b_C", 1, 1'b0, 1'b0, NPIX);
        release_bank("b2b_rel");
        read_random("b2b_B", 4);
        send_frame("b2b_D", 1, 1'b1, 1'b0, NPIX);
        read_random("b2b_B2", 2);
        release_bank("b2b_rel2");
        read_random("b2b_D", 4);
        release_bank("b2b_rel3");
    endtask

    task automatic test_release_same_cycle();
        send_frame("rsc_A", 1, 1'b0, 1'b0, NPIX);
        send_frame("rsc_B", 1, 1'b0, 1'b0, NPIX);
        send_frame("rsc_C", 1, 1'b0, 1'b1, NPIX);
        send_frame("rsc_D", 1, 1'b0, 1'b0, NPIX);
        read_random("rsc_B", 3);
        release_bank("rsc_rel");
        read_random("rsc_D", 4);
        release_bank("rsc_rel2");
    endtask

    task automatic test_invalid_reads();
        read_check("empty_read", $urandom_range(0, NPIX - 1), 8'h00);
        release_bank("empty_rel");
        send_frame("inv_E", 1, 1'b0, 1'b0, NPIX);
        read_check("oob_read", 800, 8'h00);
        read_random("inv_E", 3);
        release_bank("inv_rel");
    endtask

    task automatic test_reset_mid_frame();
        send_frame("mid_partial", 1, 1'b0, 1'b0, 400);
        apply_reset();
        chk_status("mid_reset");
        send_frame("mid_F", 1, 1'b1, 1'b0, NPIX);
        read_check("mid_F", 0, model_read(0));
        read_check("mid_F", 783, model_read(783));
        read_random("mid_F", 3);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_rowcol_gaps();
        test_back_to_back();
        test_release_same_cycle();
        test_invalid_reads();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
